// File: rtl/cpu_multicycle.sv
// Multicycle 16-bit MIPS-style core sharing one instruction/data memory port
// with a req/ready handshake. Width, address width and reset vector are parameters.
module cpu_multicycle #(
    parameter int WIDTH    = 16,
    parameter int ADDR_W   = 12,
    parameter int RESET_PC = 0
) (
    input  logic              clk,
    input  logic              rst,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [WIDTH-1:0]  mem_wdata,
    input  logic [WIDTH-1:0]  mem_rdata,
    input  logic              mem_ready,
    output logic [ADDR_W-1:0] pc,
    output logic              halt,
    output logic [31:0]       instret,
    input  logic [2:0]        dbg_sel,
    output logic [WIDTH-1:0]  dbg_data
);
    localparam logic [2:0] S_FETCH  = 3'd0;
    localparam logic [2:0] S_DECODE = 3'd1;
    localparam logic [2:0] S_EXEC   = 3'd2;
    localparam logic [2:0] S_MEM    = 3'd3;
    localparam logic [2:0] S_WB     = 3'd4;
    localparam logic [2:0] S_HALT   = 3'd5;

    localparam logic [3:0] OP_R    = 4'd0;
    localparam logic [3:0] OP_ADDI = 4'd1;
    localparam logic [3:0] OP_LW   = 4'd2;
    localparam logic [3:0] OP_SW   = 4'd3;
    localparam logic [3:0] OP_BEQ  = 4'd4;
    localparam logic [3:0] OP_BNE  = 4'd5;
    localparam logic [3:0] OP_J    = 4'd6;
    localparam logic [3:0] OP_JAL  = 4'd7;

    logic [2:0]        state_q, state_d;
    logic [ADDR_W-1:0] pc_q, pc_d;
    logic [15:0]       ir_q, ir_d;
    logic [WIDTH-1:0]  a_q, a_d, b_q, b_d, alu_q, alu_d;
    logic [31:0]       instret_q, instret_d;
    logic [WIDTH-1:0]  rf_q [8];
    logic [WIDTH-1:0]  rf_d [8];

    logic [3:0]       op;
    logic [2:0]       rs, rt, rd, funct;
    logic [WIDTH-1:0] imm;

    assign op    = ir_q[15:12];
    assign rs    = ir_q[11:9];
    assign rt    = ir_q[8:6];
    assign rd    = ir_q[5:3];
    assign funct = ir_q[2:0];
    assign imm   = {{(WIDTH-6){ir_q[5]}}, ir_q[5:0]};

    always_comb begin
        state_d   = state_q;
        pc_d      = pc_q;
        ir_d      = ir_q;
        a_d       = a_q;
        b_d       = b_q;
        alu_d     = alu_q;
        instret_d = instret_q;
        rf_d      = rf_q;
        case (state_q)
            S_FETCH: begin
                if (mem_ready) begin
                    ir_d    = mem_rdata[15:0];
                    // an illegal opcode leaves pc pointing at itself for post-mortem
                    if (!mem_rdata[15]) pc_d = pc_q + 1'b1;
                    state_d = S_DECODE;
                end
            end
            S_DECODE: begin
                if (op[3]) begin
                    state_d = S_HALT;
                end else begin
                    a_d     = rf_q[rs];
                    b_d     = rf_q[rt];
                    state_d = S_EXEC;
                end
            end
            S_EXEC: begin
                state_d = S_FETCH;
                case (op)
                    OP_R: begin
                        case (funct)
                            3'd0:    alu_d = a_q + b_q;
                            3'd1:    alu_d = a_q - b_q;
                            3'd2:    alu_d = a_q & b_q;
                            3'd3:    alu_d = a_q | b_q;
                            3'd4:    alu_d = {{(WIDTH-1){1'b0}}, $signed(a_q) < $signed(b_q)};
                            default: alu_d = alu_q;
                        endcase
                        state_d = S_WB;
                    end
                    OP_ADDI: begin
                        alu_d   = a_q + imm;
                        state_d = S_WB;
                    end
                    OP_LW, OP_SW: begin
                        alu_d   = a_q + imm;
                        state_d = S_MEM;
                    end
                    OP_BEQ, OP_BNE: begin
                        // pc already holds pc+1 from fetch
                        if ((a_q == b_q) == (op == OP_BEQ)) pc_d = pc_q + imm[ADDR_W-1:0];
                        instret_d = instret_q + 32'd1;
                    end
                    default: begin
                        if (op == OP_JAL) rf_d[7] = WIDTH'(pc_q);
                        pc_d      = ADDR_W'(ir_q[11:0]);
                        instret_d = instret_q + 32'd1;
                    end
                endcase
            end
            S_MEM: begin
                if (mem_ready) begin
                    if (op == OP_LW) begin
                        alu_d   = mem_rdata;
                        state_d = S_WB;
                    end else begin
                        instret_d = instret_q + 32'd1;
                        state_d   = S_FETCH;
                    end
                end
            end
            S_WB: begin
                if (op == OP_R) begin
                    if (funct < 3'd5 && rd != 3'd0) rf_d[rd] = alu_q;
                end else if (rt != 3'd0) begin
                    rf_d[rt] = alu_q;
                end
                instret_d = instret_q + 32'd1;
                state_d   = S_FETCH;
            end
            default: state_d = S_HALT;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= S_FETCH;
            pc_q      <= ADDR_W'(RESET_PC);
            ir_q      <= '0;
            a_q       <= '0;
            b_q       <= '0;
            alu_q     <= '0;
            instret_q <= '0;
            for (int i = 0; i < 8; i++) rf_q[i] <= '0;
        end else begin
            state_q   <= state_d;
            pc_q      <= pc_d;
            ir_q      <= ir_d;
            a_q       <= a_d;
            b_q       <= b_d;
            alu_q     <= alu_d;
            instret_q <= instret_d;
            for (int i = 0; i < 8; i++) rf_q[i] <= rf_d[i];
        end
    end

    // reset gates the request combinationally so an in-flight transfer dies at once
    assign mem_req   = rst && (state_q == S_FETCH || state_q == S_MEM);
    assign mem_we    = rst && state_q == S_MEM && op == OP_SW;
    assign mem_addr  = !rst                ? '0 :
                       state_q == S_FETCH  ? pc_q :
                       state_q == S_MEM    ? alu_q[ADDR_W-1:0] : '0;
    assign mem_wdata = mem_we ? b_q : '0;
    assign pc        = pc_q;
    assign halt      = state_q == S_HALT;
    assign instret   = instret_q;
    assign dbg_data  = (dbg_sel == 3'd0) ? '0 : rf_q[dbg_sel];
endmodule

// File: tb/tb_cpu_multicycle.sv
// Directed bench for cpu_multicycle: default 16-bit core with a wait-stated
// memory model, plus a 32-bit / 16-bit-address instance with a moved reset vector.
module tb_cpu_multicycle;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst0 = 1'b1, rst1 = 1'b1;
    int   n_chk = 0, n_pass = 0;

    logic        mem_req0, mem_we0, mem_ready0, halt0;
    logic [11:0] mem_addr0, pc0;
    logic [15:0] mem_wdata0, mem_rdata0, dbg_data0;
    logic [31:0] instret0;
    logic [2:0]  dbg_sel0 = 3'd0;

    logic        mem_req1, mem_we1, halt1;
    logic        mem_ready1 = 1'b1;
    logic [15:0] mem_addr1, pc1;
    logic [31:0] mem_wdata1, mem_rdata1, dbg_data1, instret1;
    logic [2:0]  dbg_sel1 = 3'd0;

    logic [15:0] mem0 [4096];
    logic [31:0] mem1 [256];
    int          wcnt = 0;
    logic        wait_en = 1'b0;
    logic        ld_en = 1'b0;
    logic [11:0] ld_addr = '0;
    logic [15:0] ld_data = '0;
    logic        in_wait;

    // two wait states on data accesses in 0x020..0x02F, none elsewhere
    assign in_wait    = wait_en && mem_addr0 >= 12'h020 && mem_addr0 < 12'h030;
    assign mem_ready0 = !in_wait || wcnt >= 2;
    assign mem_rdata0 = mem0[mem_addr0];
    assign mem_rdata1 = mem1[mem_addr1[7:0]];

    always @(posedge clk) begin
        if (mem_req0 && !mem_ready0) wcnt <= wcnt + 1;
        else                         wcnt <= 0;
        if (ld_en)                                   mem0[ld_addr] <= ld_data;
        else if (mem_req0 && mem_we0 && mem_ready0) mem0[mem_addr0] <= mem_wdata0;
    end

    cpu_multicycle dut0 (
        .clk(clk), .rst(rst0), .mem_req(mem_req0), .mem_we(mem_we0),
        .mem_addr(mem_addr0), .mem_wdata(mem_wdata0), .mem_rdata(mem_rdata0),
        .mem_ready(mem_ready0), .pc(pc0), .halt(halt0), .instret(instret0),
        .dbg_sel(dbg_sel0), .dbg_data(dbg_data0)
    );

    cpu_multicycle #(.WIDTH(32), .ADDR_W(16), .RESET_PC(32'h40)) dut1 (
        .clk(clk), .rst(rst1), .mem_req(mem_req1), .mem_we(mem_we1),
        .mem_addr(mem_addr1), .mem_wdata(mem_wdata1), .mem_rdata(mem_rdata1),
        .mem_ready(mem_ready1), .pc(pc1), .halt(halt1), .instret(instret1),
        .dbg_sel(dbg_sel1), .dbg_data(dbg_data1)
    );

    function automatic logic [15:0] enc_i(input logic [3:0] op, input logic [2:0] rs,
                                          input logic [2:0] rt, input int imm);
        return {op, rs, rt, 6'(imm)};
    endfunction

    function automatic logic [15:0] enc_r(input logic [2:0] rs, input logic [2:0] rt,
                                          input logic [2:0] rd, input logic [2:0] f);
        return {4'h0, rs, rt, rd, f};
    endfunction

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic put(input logic [11:0] a, input logic [15:0] d);
        ld_addr = a;
        ld_data = d;
        ld_en   = 1'b1;
        @(posedge clk);
        #1;
        ld_en = 1'b0;
    endtask

    task automatic rd0(input string tag, input logic [2:0] r, input logic [15:0] exp);
        dbg_sel0 = r;
        #1;
        chk(tag, dbg_data0, exp);
    endtask

    task automatic reset0();
        @(negedge clk);
        rst0 = 1'b0;
    endtask

    task automatic start0();
        @(negedge clk);
        rst0 = 1'b1;
    endtask

    initial begin
        #2;
        rst0 = 1'b0;
        rst1 = 1'b0;
        mem1[8'h40] = 32'hABCD_0000 | {16'h0, enc_i(4'd1, 3'd0, 3'd1, -1)};
        mem1[8'h41] = 32'h5555_0000 | {16'h0, enc_r(3'd1, 3'd1, 3'd1, 3'd0)};
        mem1[8'h42] = {16'h0, enc_i(4'd4, 3'd0, 3'd0, -1)};

        // arithmetic program, loaded while reset is held with ready high
        put(12'h000, enc_i(4'd1, 3'd0, 3'd1, 5));
        put(12'h001, enc_i(4'd1, 3'd0, 3'd2, -3));
        put(12'h002, enc_r(3'd1, 3'd2, 3'd3, 3'd0));
        put(12'h003, enc_r(3'd2, 3'd1, 3'd4, 3'd4));
        put(12'h004, enc_r(3'd1, 3'd1, 3'd0, 3'd0));
        put(12'h005, enc_i(4'd4, 3'd0, 3'd0, -1));
        tick(2);
        chk("rst_req", mem_req0, 1'b0);
        chk("rst_pc", pc0, 12'h000);
        chk("rst_instret", instret0, 32'd0);
        chk("rst_halt", halt0, 1'b0);
        chk("rst_addr", mem_addr0, 12'h000);
        start0();
        #1;
        chk("rel_req", mem_req0, 1'b1);
        chk("rel_addr", mem_addr0, 12'h000);
        tick(15);
        chk("ar_instret15", instret0, 32'd3);
        tick(1);
        chk("ar_instret16", instret0, 32'd4);
        chk("ar_pc16", pc0, 12'h004);
        rd0("ar_r1", 3'd1, 16'h0005);
        rd0("ar_r2", 3'd2, 16'hFFFD);
        rd0("ar_r3", 3'd3, 16'h0002);
        rd0("ar_r4_slt", 3'd4, 16'h0001);
        tick(4);
        chk("ar_instret20", instret0, 32'd5);
        rd0("ar_r0", 3'd0, 16'h0000);
        tick(3);
        chk("beq_instret", instret0, 32'd6);
        chk("beq_pc", pc0, 12'h005);
        tick(30);
        chk("beq_loop_instret", instret0, 32'd16);
        chk("beq_loop_pc", pc0, 12'h005);

        // memory with two data wait states
        reset0();
        put(12'h020, 16'h0000);
        put(12'h000, enc_i(4'd1, 3'd0, 3'd1, 5));
        put(12'h001, enc_i(4'd1, 3'd0, 3'd6, 16));
        put(12'h002, enc_i(4'd3, 3'd6, 3'd1, 16));
        put(12'h003, enc_i(4'd2, 3'd6, 3'd5, 16));
        put(12'h004, enc_i(4'd4, 3'd0, 3'd0, -1));
        wait_en = 1'b1;
        start0();
        tick(8);
        chk("mem_instret8", instret0, 32'd2);
        tick(3);
        chk("sw_req", mem_req0, 1'b1);
        chk("sw_we", mem_we0, 1'b1);
        chk("sw_addr", mem_addr0, 12'h020);
        chk("sw_wdata", mem_wdata0, 16'h0005);
        tick(1);
        chk("sw_we_hold", mem_we0, 1'b1);
        chk("sw_addr_hold", mem_addr0, 12'h020);
        chk("sw_wdata_hold", mem_wdata0, 16'h0005);
        tick(1);
        chk("sw_pending", instret0, 32'd2);
        tick(1);
        chk("sw_retired", instret0, 32'd3);
        chk("sw_we_drop", mem_we0, 1'b0);
        chk("sw_stored", mem0[12'h020], 16'h0005);
        tick(4);
        chk("lw_req", mem_req0, 1'b1);
        chk("lw_we", mem_we0, 1'b0);
        chk("lw_addr", mem_addr0, 12'h020);
        tick(2);
        chk("lw_pending", instret0, 32'd3);
        tick(1);
        chk("lw_retired", instret0, 32'd4);
        rd0("lw_r5", 3'd5, 16'h0005);
        wait_en = 1'b0;

        // control flow and pc wrap
        reset0();
        put(12'h000, enc_i(4'd1, 3'd0, 3'd1, 1));
        put(12'h001, enc_i(4'd5, 3'd1, 3'd1, 5));
        put(12'h002, 16'h7100);
        put(12'h100, 16'h6FFF);
        put(12'hFFF, enc_i(4'd1, 3'd0, 3'd3, 9));
        start0();
        tick(7);
        chk("bne_nt_pc", pc0, 12'h002);
        chk("bne_nt_instret", instret0, 32'd2);
        tick(3);
        chk("jal_pc", pc0, 12'h100);
        chk("jal_instret", instret0, 32'd3);
        rd0("jal_r7", 3'd7, 16'h0003);
        tick(3);
        chk("j_pc", pc0, 12'hFFF);
        tick(1);
        chk("wrap_pc", pc0, 12'h000);
        tick(3);
        chk("wrap_instret", instret0, 32'd5);
        rd0("wrap_r3", 3'd3, 16'h0009);

        // illegal opcode at pc 4
        reset0();
        put(12'h000, enc_i(4'd1, 3'd0, 3'd1, 1));
        put(12'h001, enc_i(4'd1, 3'd1, 3'd1, 1));
        put(12'h002, enc_i(4'd1, 3'd1, 3'd1, 1));
        put(12'h003, enc_i(4'd1, 3'd1, 3'd1, 1));
        put(12'h004, 16'hF000);
        start0();
        tick(16);
        chk("ill_pre_instret", instret0, 32'd4);
        tick(1);
        chk("ill_decode_halt", halt0, 1'b0);
        chk("ill_decode_pc", pc0, 12'h004);
        tick(1);
        chk("ill_halt", halt0, 1'b1);
        chk("ill_req", mem_req0, 1'b0);
        tick(20);
        chk("ill_frozen_pc", pc0, 12'h004);
        chk("ill_frozen_instret", instret0, 32'd4);
        chk("ill_frozen_halt", halt0, 1'b1);
        chk("ill_frozen_req", mem_req0, 1'b0);
        rd0("ill_r1", 3'd1, 16'h0004);
        rst0 = 1'b0;
        #1;
        chk("ill_rst_halt", halt0, 1'b0);
        chk("ill_rst_instret", instret0, 32'd0);

        // wide instance with moved reset vector
        @(negedge clk);
        rst1 = 1'b1;
        #1;
        chk("w_req", mem_req1, 1'b1);
        chk("w_first_addr", mem_addr1, 16'h0040);
        tick(4);
        dbg_sel1 = 3'd1;
        #1;
        chk("w_addi_m1", dbg_data1, 32'hFFFF_FFFF);
        chk("w_instret1", instret1, 32'd1);
        tick(4);
        chk("w_add_wrap", dbg_data1, 32'hFFFF_FFFE);
        chk("w_instret2", instret1, 32'd2);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
